// File: rtl/microcore_sequencer_pkg.sv
// Shared constants and types for the microcore sequencer.
// SHA-256 round constants, padding words and sequencer states.
package microcore_sequencer_pkg;

   localparam int SHA_PASS_LEN = 68;

   localparam logic [31:0] PAD_START = 32'h8000_0000;
   localparam logic [31:0] PAD_LEN1  = 32'h0000_0280;
   localparam logic [31:0] PAD_LEN2  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } seq_state_e;

   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, indexed by the round counter.
// Counts past round 63 return K[0]; the pass tail does not use them.
module sha256_k_rom
   import microcore_sequencer_pkg::*;
(
   input  logic [7:0]  addr,
   output logic [31:0] k
);

   // Table read with an in-range guard on the upper counter values.
   always_comb begin
      k = K_TABLE[0];
      if (addr < 8'd64) k = K_TABLE[addr[5:0]];
   end

endmodule

// File: rtl/microcore_sequencer.sv
// Drives round counter, constants and message words to the microcores,
// advances the nonce base per job and collects golden-nonce hits.
module microcore_sequencer
   import microcore_sequencer_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int PASS_LEN  = SHA_PASS_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [255:0]         midstate_in,
   input  logic [95:0]          data_in,
   output logic [255:0]         midstate,
   output logic [31:0]          m7,
   output logic [7:0]           cnt,
   output logic                 pass,
   output logic [31:0]          k_in,
   output logic [31:0]          r1_in,
   input  logic [NUM_CORES-1:0] gnon,
   output logic                 golden_valid,
   output logic [31:0]          golden_nonce,
   output logic                 golden_lost,
   output logic                 exhausted
);

   localparam logic [7:0]  CNT_LAST = 8'(PASS_LEN - 1);
   localparam logic [32:0] STRIDE   = 33'(NUM_CORES);

   seq_state_e  state, state_nx;
   logic [7:0]  cnt_nx;
   logic        pass_nx;
   logic [31:0] base, prev_base;
   logic [95:0] data;
   logic        armed;
   logic [32:0] base_sum;
   logic        overflow, pass_end, hit_sample;
   logic [31:0] hit_idx;
   logic        hit_multi;

   assign base_sum   = {1'b0, base} + STRIDE;
   assign overflow   = base_sum[32];
   assign pass_end   = (state == ST_RUN) && pass && (cnt == CNT_LAST);
   assign hit_sample = armed && (state == ST_RUN) && (cnt == 8'd1)
                       && !pass && (|gnon);

   sha256_k_rom u_k_rom (
      .addr (cnt),
      .k    (k_in)
   );

   // State, round counter and pass flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 8'd0;
         pass  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pass  <= pass_nx;
      end
   end

   // Next state: count through two passes per job, halt on nonce wrap.
   always_comb begin
      state_nx = state;
      cnt_nx   = 8'd0;
      pass_nx  = 1'b0;
      unique case (state)
         ST_RUN: begin
            cnt_nx  = cnt + 8'd1;
            pass_nx = pass;
            if (cnt == CNT_LAST) begin
               cnt_nx  = 8'd0;
               pass_nx = ~pass;
               if (pass && overflow) begin
                  state_nx = ST_HALT;
               end
            end
         end
         ST_IDLE, ST_HALT: ;
         default: state_nx = ST_IDLE;
      endcase
      if (load) begin
         state_nx = ST_RUN;
         cnt_nx   = 8'd0;
         pass_nx  = 1'b0;
      end
   end

   // Work latch and nonce base bookkeeping at each job boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         base      <= '0;
         prev_base <= '0;
         armed     <= 1'b0;
         exhausted <= 1'b0;
         midstate  <= '0;
         m7        <= '0;
         data      <= '0;
      end else if (load) begin
         base      <= '0;
         armed     <= 1'b0;
         exhausted <= 1'b0;
         midstate  <= midstate_in;
         m7        <= midstate_in[255:224];
         data      <= data_in;
      end else if (pass_end) begin
         prev_base <= base;
         armed     <= 1'b1;
         if (overflow) exhausted <= 1'b1;
         else          base      <= base_sum[31:0];
      end
   end

   // Lowest set core flag wins; extra flags mark the hit as lossy.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (gnon[i]) hit_idx = 32'(i);
      end
      hit_multi = ($countones(gnon) > 1);
   end

   // Golden report registers; a concurrent load does not drop the hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         golden_valid <= 1'b0;
         golden_nonce <= '0;
         golden_lost  <= 1'b0;
      end else begin
         golden_valid <= hit_sample;
         if (load) golden_lost <= 1'b0;
         if (hit_sample) begin
            golden_nonce <= prev_base + hit_idx;
            if (hit_multi) golden_lost <= 1'b1;
         end
      end
   end

   // Message word / nonce / padding selection aligned to cnt.
   always_comb begin
      r1_in = '0;
      if (!pass) begin
         case (cnt)
            8'd0:    r1_in = data[31:0];
            8'd1:    r1_in = data[63:32];
            8'd2:    r1_in = data[95:64];
            8'd3:    r1_in = base;
            8'd4:    r1_in = PAD_START;
            8'd15:   r1_in = PAD_LEN1;
            default: r1_in = '0;
         endcase
      end else begin
         case (cnt)
            8'd8:    r1_in = PAD_START;
            8'd15:   r1_in = PAD_LEN2;
            default: r1_in = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_microcore_sequencer.sv
// Bench for microcore_sequencer: random work and core flags checked
// each cycle against a job-timeline model plus directed spot checks.
module tb_microcore_sequencer;

   localparam int NC = 4;
   localparam int PL = 68;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [255:0]  midstate_in = '0;
   logic [95:0]   data_in = '0;
   logic [255:0]  midstate;
   logic [31:0]   m7, k_in, r1_in, golden_nonce;
   logic [7:0]    cnt;
   logic          pass, golden_valid, golden_lost, exhausted;
   logic [NC-1:0] gnon = '0;

   microcore_sequencer #(.NUM_CORES(NC), .PASS_LEN(PL)) dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .midstate_in  (midstate_in),
      .data_in      (data_in),
      .midstate     (midstate),
      .m7           (m7),
      .cnt          (cnt),
      .pass         (pass),
      .k_in         (k_in),
      .r1_in        (r1_in),
      .gnon         (gnon),
      .golden_valid (golden_valid),
      .golden_nonce (golden_nonce),
      .golden_lost  (golden_lost),
      .exhausted    (exhausted)
   );

   always #5 clk = ~clk;

   logic [31:0] kt [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   int npass = 0;
   int ntotal = 0;

   // model: mode 0 idle, 1 run, 2 halt; t = cycles since load
   int           mode = 0;
   int           t = 0;
   logic [31:0]  m_base0 = '0;
   logic [255:0] m_ms = '0;
   logic [95:0]  m_data = '0;
   logic         m_gv = 1'b0;
   logic [31:0]  m_gn = '0;
   logic         m_lost = 1'b0;
   logic         m_exh = 1'b0;
   logic [3:0]   hit_tab [8];
   logic [31:0]  q_gn [$];
   logic [31:0]  q_n3 [$];

   function automatic int m_cnt();
      return (mode == 1) ? (t % PL) : 0;
   endfunction

   function automatic int m_pass();
      return (mode == 1) ? ((t / PL) % 2) : 0;
   endfunction

   function automatic int m_job();
      return t / (2 * PL);
   endfunction

   function automatic logic [31:0] cur_base();
      return m_base0 + 32'(NC * m_job());
   endfunction

   function automatic logic [31:0] exp_r1(int c, int p);
      if (p == 0) begin
         if (c < 3) return m_data[32*c +: 32];
         if (c == 3) return cur_base();
         if (c == 4) return 32'h8000_0000;
         if (c == 15) return 32'h0000_0280;
         return 32'h0;
      end
      if (c == 8) return 32'h8000_0000;
      if (c == 15) return 32'h0000_0100;
      return 32'h0;
   endfunction

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One cycle: pick flags, check at negedge, advance model, clock.
   task automatic step();
      int          c, p, idx, ones;
      logic        hit;
      logic [31:0] hn;
      c = m_cnt();
      p = m_pass();
      if (mode == 1 && c == 1 && p == 0) gnon = hit_tab[m_job() % 8];
      else gnon = NC'($urandom_range(0, 15));
      @(negedge clk);
      if (golden_valid === 1'b1) q_gn.push_back(golden_nonce);
      if (mode == 1 && c == 3 && p == 0) q_n3.push_back(r1_in);
      chk("cnt", 256'(cnt), 256'(c));
      chk("pass", 256'(pass), 256'(p));
      chk("k_in", 256'(k_in), 256'(c < 64 ? kt[c] : kt[0]));
      chk("r1_in", 256'(r1_in), 256'(exp_r1(c, p)));
      chk("midstate", midstate, m_ms);
      chk("m7", 256'(m7), 256'(m_ms[255:224]));
      chk("golden_valid", 256'(golden_valid), 256'(m_gv));
      chk("golden_nonce", 256'(golden_nonce), 256'(m_gn));
      chk("golden_lost", 256'(golden_lost), 256'(m_lost));
      chk("exhausted", 256'(exhausted), 256'(m_exh));
      if (mode == 1 && c == 0) chk("k0", 256'(k_in), 256'(32'h428a2f98));
      if (mode == 1 && c == 63) chk("k63", 256'(k_in), 256'(32'hc67178f2));
      if (reset) begin
         mode = 0; t = 0; m_base0 = '0; m_ms = '0; m_data = '0;
         m_gv = 1'b0; m_gn = '0; m_lost = 1'b0; m_exh = 1'b0;
      end else begin
         idx = -1;
         ones = 0;
         for (int i = 0; i < NC; i++) begin
            if (gnon[i]) begin
               ones++;
               if (idx < 0) idx = i;
            end
         end
         hit = (mode == 1) && (t >= 2 * PL) && c == 1 && p == 0 && ones > 0;
         hn = cur_base() - 32'(NC) + 32'(idx);
         if (load) begin
            mode = 1; t = 0; m_base0 = '0;
            m_ms = midstate_in; m_data = data_in;
            m_exh = 1'b0; m_lost = 1'b0;
         end else if (mode == 1) begin
            if (c == PL - 1 && p == 1 &&
                (64'(cur_base()) + 64'(NC)) > 64'hFFFF_FFFF) begin
               mode = 2;
               m_exh = 1'b1;
            end else begin
               t++;
            end
         end
         m_gv = hit;
         if (hit) begin
            m_gn = hn;
            if (ones > 1) m_lost = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      reset = 1'b0;
   endtask

   task automatic new_work();
      for (int i = 0; i < 8; i++) midstate_in[32*i +: 32] = $urandom;
      for (int i = 0; i < 3; i++) data_in[32*i +: 32] = $urandom;
      load = 1'b1;
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 8; i++) hit_tab[i] = 4'($urandom_range(0, 15));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      step();

      // three jobs with directed flags: unarmed, none, single, double
      hit_tab[0] = 4'b1111;
      hit_tab[1] = 4'b0000;
      hit_tab[2] = 4'b0100;
      hit_tab[3] = 4'b1010;
      hit_tab[4] = 4'b0001;
      new_work();
      step();
      repeat (3 * 2 * PL + 10) step();
      chk("pulses", 256'(q_gn.size()), 256'(2));
      chk("hit_single", 256'(q_gn[0]), 256'(32'd6));
      chk("hit_double", 256'(q_gn[1]), 256'(32'd9));
      chk("lost_sticky", 256'(golden_lost), 256'(1'b1));
      chk("nonce_j0", 256'(q_n3[0]), 256'(32'd0));
      chk("nonce_j1", 256'(q_n3[1]), 256'(32'd4));
      chk("nonce_j2", 256'(q_n3[2]), 256'(32'd8));

      // load coincident with a sampled hit in job 4
      guard = 0;
      while (!(m_job() == 4 && m_cnt() == 1 && m_pass() == 0) && guard < 300) begin
         step();
         guard++;
      end
      chk("reach_job4", 256'(guard < 300), 256'(1'b1));
      new_work();
      step();
      chk("load_cnt0", 256'(cnt), 256'(8'd0));
      chk("load_hit_pulse", 256'(golden_valid), 256'(1'b1));
      chk("load_hit_nonce", 256'(golden_nonce), 256'(32'd12));
      for (int i = 0; i < 8; i++) hit_tab[i] = 4'($urandom_range(0, 15));
      repeat (2 * 2 * PL + 5) step();

      // nonce space exhaustion
      new_work();
      step();
      force dut.base = 32'hFFFF_FFFC;
      #1;
      release dut.base;
      m_base0 = 32'hFFFF_FFFC;
      repeat (2 * PL + 8) step();
      chk("exhausted", 256'(exhausted), 256'(1'b1));
      chk("halt_cnt", 256'(cnt), 256'(8'd0));
      q_n3.delete();
      new_work();
      step();
      repeat (2 * PL + 4) step();
      chk("exh_cleared", 256'(exhausted), 256'(1'b0));
      chk("base_restart", 256'(q_n3[0]), 256'(32'd0));

      // reset mid pass 1, together with a load it must override
      for (int i = 0; i < 8; i++) hit_tab[i] = 4'b1111;
      guard = 0;
      while (!(m_pass() == 1 && m_cnt() == 30) && guard < 300) begin
         step();
         guard++;
      end
      chk("reach_p1c30", 256'(guard < 300), 256'(1'b1));
      reset = 1'b1;
      new_work();
      step();
      chk("rst_cnt", 256'(cnt), 256'(8'd0));
      chk("rst_midstate", midstate, 256'(0));
      chk("rst_nonce", 256'(golden_nonce), 256'(32'd0));
      q_gn.delete();
      repeat (300) step();
      chk("no_pulse_after_rst", 256'(q_gn.size()), 256'(0));

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
